// File: rtl/dmem_responder_if.sv
// Request/response channel between the CPU data-memory port (master) and the responder (slave).
interface dmem_responder_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [31:0]           req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder: one request at a time, fixed wait states,
// load data or store acknowledge, with misalignment / range error flagging.
module dmem_responder #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 5300,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    dmem_responder_if.slave     dmem,
    output logic                busy,
    output logic [31:0]         access_count
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  resp_err_q, resp_err_d;
    logic                  valid_q, valid_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic [31:0]           count_q, count_d;
    logic                  addr_err_c;
    logic                  access_c;
    logic                  mem_we_c;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Range check on the full word index, so high address bits can never alias into the array.
    assign addr_err_c = (dmem.req_addr[1:0] != 2'b00) ||
                        ({2'b00, dmem.req_addr[31:2]} >= 32'(DEPTH));
    assign access_c   = (state_q == S_WAIT) && (cnt_q == '0);
    assign mem_we_c   = access_c && we_q && !err_q;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (dmem.req_valid) state_d = S_WAIT;
            S_WAIT:  if (cnt_q == '0)    state_d = S_RESP;
            S_RESP:  if (dmem.resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered handshake outputs, all derived from the upcoming state.
    always_comb begin
        cnt_d      = cnt_q;
        we_d       = we_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        resp_err_d = resp_err_q;
        count_d    = count_q;

        if ((state_q == S_IDLE) && dmem.req_valid) begin
            we_d    = dmem.req_we;
            idx_d   = dmem.req_addr[IDX_W+1:2];
            wdata_d = dmem.req_wdata;
            err_d   = addr_err_c;
            cnt_d   = CNT_W'(WAIT_CYCLES);
        end

        if ((state_q == S_WAIT) && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        if (access_c) begin
            rdata_d    = (we_q || err_q) ? '0 : mem[idx_q];
            resp_err_d = err_q;
        end

        if ((state_q == S_RESP) && dmem.resp_ready && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end

        ready_d = (state_d == S_IDLE);
        valid_d = (state_d == S_RESP);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            we_q       <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            resp_err_q <= 1'b0;
            valid_q    <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            resp_err_q <= resp_err_d;
            valid_q    <= valid_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            count_q    <= count_d;
        end
    end

    // Backing array is not reset; contents survive a reset.
    always_ff @(posedge CLOCK_50) begin
        if (mem_we_c) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign dmem.req_ready  = ready_q;
    assign dmem.resp_valid = valid_q;
    assign dmem.resp_rdata = rdata_q;
    assign dmem.resp_err   = resp_err_q;
    assign busy            = busy_q;
    assign access_count    = count_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed scenarios plus randomized loads/stores
// against a word-indexed reference memory; a second instance with no wait states checks throughput.
module tb_dmem_responder;

    localparam int unsigned DEPTH   = 5300;
    localparam int unsigned WAITS   = 2;
    localparam int unsigned DEPTH0  = 64;
    localparam int          LAT     = WAITS + 1;

    logic        clk;
    logic        rst;
    logic        busy, busy0;
    logic [31:0] acc_cnt, acc_cnt0;

    dmem_responder_if #(.DATA_WIDTH(32)) bus  ();
    dmem_responder_if #(.DATA_WIDTH(32)) bus0 ();

    dmem_responder #(.DATA_WIDTH(32), .DEPTH(DEPTH), .WAIT_CYCLES(WAITS)) u_dut (
        .CLOCK_50     (clk),
        .reset        (rst),
        .dmem         (bus.slave),
        .busy         (busy),
        .access_count (acc_cnt)
    );

    dmem_responder #(.DATA_WIDTH(32), .DEPTH(DEPTH0), .WAIT_CYCLES(0)) u_dut0 (
        .CLOCK_50     (clk),
        .reset        (rst),
        .dmem         (bus0.slave),
        .busy         (busy0),
        .access_count (acc_cnt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        bit          chk;
    } exp_t;

    exp_t         exp_q[$];
    logic [31:0]  model_mem [int unsigned];
    int           n_tests = 0;
    int           n_fail  = 0;
    logic [31:0]  exp_count = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic is_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (longint'(a) >= 4 * longint'(DEPTH));
    endfunction

    // Monitor: a response is consumed at the next rising edge whenever valid and ready are both high.
    always @(negedge clk) begin
        if (!rst && bus.resp_valid && bus.resp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 64'(1), 64'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_err", 64'(bus.resp_err), 64'(e.err));
                if (e.chk) check("resp_rdata", 64'(bus.resp_rdata), 64'(e.rdata));
            end
        end
    end

    // Issue one request, check its latency, stall the response, then complete the handshake.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int stall);
        exp_t        e;
        int          guard;
        int          lat;
        int unsigned w;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        guard = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("req_ready_timeout", 64'(0), 64'(1));
        @(posedge clk);
        w     = addr >> 2;
        e.err = is_err(addr);
        e.chk = 1'b1;
        e.rdata = 32'h0;
        if (!e.err) begin
            if (we) model_mem[w] = wdata;
            else if (model_mem.exists(w)) e.rdata = model_mem[w];
            else e.chk = 1'b0;
        end
        exp_q.push_back(e);
        #1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.resp_valid && lat < 20);
        check("latency", 64'(lat), 64'(LAT));
        repeat (stall) begin
            @(negedge clk);
            check("stall_valid", 64'(bus.resp_valid), 64'(1));
            check("stall_ready", 64'(bus.req_ready), 64'(0));
            check("stall_busy", 64'(busy), 64'(1));
            check("stall_count", 64'(acc_cnt), 64'(exp_count));
        end
        if (stall > 0) begin
            @(posedge clk); #1;
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        if (exp_count != 32'hFFFF_FFFF) exp_count++;
        check("count_after", 64'(acc_cnt), 64'(exp_count));
        check("valid_cleared", 64'(bus.resp_valid), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic        we;
        rst = 1'b1;
        bus.req_valid = 0; bus.req_we = 0; bus.req_addr = 0; bus.req_wdata = 0; bus.resp_ready = 0;
        bus0.req_valid = 0; bus0.req_we = 0; bus0.req_addr = 0; bus0.req_wdata = 0;
        bus0.resp_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 64'(1));
        check("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
        check("rst_count", 64'(acc_cnt), 64'(0));
        rst = 1'b0;

        // Store then load the same word.
        do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 0);
        do_req(1'b0, 32'h10, 32'h0, 0);
        check("count_two", 64'(acc_cnt), 64'(2));
        do_req(1'b1, 32'h4, 32'hA5A5_5A5A, 1);
        do_req(1'b1, 32'h20, 32'h0000_CAFE, 0);
        // Long backpressure on a load.
        do_req(1'b0, 32'h10, 32'h0, 5);
        // Error cases must not disturb the array.
        do_req(1'b1, 32'h6, 32'h1111_2222, 0);
        do_req(1'b0, 4 * DEPTH, 32'h0, 0);
        do_req(1'b1, 32'h8000_0004, 32'h3333_4444, 0);
        do_req(1'b0, 32'h4, 32'h0, 0);
        do_req(1'b0, 4 * (DEPTH - 1), 32'h0, 0);

        // Store aborted by reset after one wait cycle: no write, no response.
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h20; bus.req_wdata = 32'h1234;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        check("async_req_ready", 64'(bus.req_ready), 64'(1));
        check("async_resp_valid", 64'(bus.resp_valid), 64'(0));
        check("async_rdata", 64'(bus.resp_rdata), 64'(0));
        check("async_err", 64'(bus.resp_err), 64'(0));
        check("async_busy", 64'(busy), 64'(0));
        check("async_count", 64'(acc_cnt), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        exp_count = 0;
        repeat (5) begin
            @(negedge clk);
            check("abort_no_resp", 64'(bus.resp_valid), 64'(0));
        end
        do_req(1'b0, 32'h20, 32'h0, 0);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom);
            case ($urandom_range(0, 9))
                0:       a = 32'($urandom_range(0, 63));
                1:       a = 4 * DEPTH + 4 * 32'($urandom_range(0, 7));
                2:       a = 32'h8000_0000 | (4 * 32'($urandom_range(0, 15)));
                3:       a = 4 * (DEPTH - 1 - 32'($urandom_range(0, 3)));
                default: a = 4 * 32'($urandom_range(0, 15));
            endcase
            do_req(we, a, $urandom, int'($urandom_range(0, 3)));
        end
        check("queue_drained", 64'(exp_q.size()), 64'(0));

        // Zero-wait instance: request held high streams with a three-cycle period.
        @(posedge clk); #1;
        bus0.req_valid = 1'b1; bus0.req_we = 1'b0; bus0.req_addr = 32'h8;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            check("z_req_ready", 64'(bus0.req_ready), 64'((n % 3) == 0));
            check("z_resp_valid", 64'(bus0.resp_valid), 64'((n % 3) == 2));
            if ((n % 3) == 2) check("z_resp_err", 64'(bus0.resp_err), 64'(0));
        end
        @(posedge clk); #1;
        bus0.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("z_count", 64'(acc_cnt0), 64'(4));
        check("z_idle", 64'(busy0), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
